// File: rtl/ballot_box_pkg.sv
// Shared types and sizing helpers for the ballot collector.
// The sizing helpers let modules derive widths from their own N/M parameters.
package ballot_box_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int DEF_N      = 2;
  localparam int DEF_M      = 2;
  localparam int NUM_VOTERS = 2 ** DEF_M;
  localparam int VOTE_W     = NUM_VOTERS * DEF_N;

  function automatic int num_voters(input int m);
    return 2 ** m;
  endfunction

  function automatic int vote_width(input int n, input int m);
    return (2 ** m) * n;
  endfunction

endpackage

// File: rtl/decoder.sv
// Binary-to-one-hot decoder: out has exactly the bit selected by in set.
module decoder #(
  parameter int N = 2
) (
  input  logic [N-1:0]      in,
  output logic [(2**N)-1:0] out
);

  always_comb begin
    // NOTE: assigning a default before the indexed write keeps every bit driven on every path, so no latch is inferred.
    out     = '0;
    out[in] = 1'b1;
  end

endmodule

// File: rtl/ballot_box.sv
// Collects one ballot per voter over valid/ready, rejects repeats, and presents
// the packed ballot set to the tally side until it is acknowledged.
module ballot_box
  import ballot_box_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [M-1:0]            in_voter,
  input  logic [N-1:0]            in_vote,
  output logic                    in_ready,
  output logic                    dup_err,
  output logic [M:0]              voted_cnt,
  output logic [vote_width(N,M)-1:0] vote,
  output logic                    vote_valid,
  input  logic                    vote_ack
);

  localparam int         NV       = num_voters(M);
  localparam logic [M:0] LAST_CNT = (M+1)'(NV - 1);

  state_t          state;
  logic [NV-1:0]   voted_mask;
  logic [NV-1:0]   voter_sel;
  logic            accept;
  logic            is_dup;
  logic            fresh;

  decoder #(.N(M)) u_voter_dec (
    .in  (in_voter),
    .out (voter_sel)
  );

  // Handshake outputs are pure decodes of the state flop, never of inputs.
  assign in_ready   = (state == COLLECT);
  assign vote_valid = (state == PRESENT);

  assign accept = in_valid & in_ready;
  assign is_dup = |(voted_mask & voter_sel);
  assign fresh  = accept & ~is_dup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        COLLECT: if (fresh && voted_cnt == LAST_CNT) state <= PRESENT;
        PRESENT: if (vote_ack) state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: ballot slots are reset because unwritten slots must read as zero; this is a flop array, not a RAM.
      voted_mask <= '0;
      voted_cnt  <= '0;
      vote       <= '0;
    end else if (state == PRESENT) begin
      if (vote_ack) begin
        voted_mask <= '0;
        voted_cnt  <= '0;
        vote       <= '0;
      end
    end else if (fresh) begin
      voted_mask <= voted_mask | voter_sel;
      voted_cnt  <= voted_cnt + (M+1)'(1);
      for (int i = 0; i < NV; i++) begin
        if (voter_sel[i]) vote[i*N +: N] <= in_vote;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dup_err <= 1'b0;
    else        dup_err <= accept & is_dup;
  end

endmodule
